// File: rtl/spongent_pkg.sv
// SPONGENT shared tables and helpers: S-box, pLayer bit index, lCounter step, bit reversal.
// Pure constants and functions; no latency, no handshake.
package spongent_pkg;

  localparam logic [3:0] SBOX [16] = '{
    4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
    4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6
  };

  // Destination of bit j; the product is formed at 64 bits so wide states cannot overflow.
  function automatic int player_idx(input int j, input int b);
    longint p;
    p = (longint'(j) * longint'(b)) / 64'sd4;
    return int'(p % longint'(b - 1));
  endfunction

  function automatic logic [31:0] lc_step(input logic [31:0] lc, input logic [32:0] poly,
                                          input int w);
    logic fb;
    fb = 1'b0;
    for (int k = 1; k <= w; k++) fb = fb ^ (lc[k-1] & poly[k]);
    return ((lc << 1) | {31'd0, fb}) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < w; k++) r[k] = v[w-1-k];
    return r;
  endfunction

endpackage

// File: rtl/spongent_round.sv
// One combinational SPONGENT round: lCounter injection, S-box layer, pLayer.
// Zero latency; no handshake.
module spongent_round
  import spongent_pkg::*;
#(
  parameter int B    = 88,
  parameter int LC_W = 6
) (
  input  logic [B-1:0]    state_i,
  input  logic [LC_W-1:0] lc_i,
  output logic [B-1:0]    state_o
);

  logic [LC_W-1:0] lc_rev;
  logic [B-1:0]    x;
  logic [B-1:0]    s;

  always_comb begin
    lc_rev          = LC_W'(bitrev(32'(lc_i), LC_W));
    x               = state_i;
    x[LC_W-1:0]     = x[LC_W-1:0] ^ lc_i;
    x[B-1 -: LC_W]  = x[B-1 -: LC_W] ^ lc_rev;
  end

  for (genvar n = 0; n < B / 4; n++) begin : g_sbox
    assign s[4*n +: 4] = SBOX[x[4*n +: 4]];
  end

  for (genvar j = 0; j < B - 1; j++) begin : g_player
    assign state_o[player_idx(j, B)] = s[j];
  end
  assign state_o[B-1] = s[B-1];

endmodule

// File: rtl/spongent_perm_iter.sv
// Iterative SPONGENT permutation, UNROLL rounds per clock; result after R/UNROLL RUN cycles.
// Input accepted only when idle; result held in DONE until out_ready.
module spongent_perm_iter
  import spongent_pkg::*;
#(
  parameter int              B       = 88,
  parameter int              R       = 45,
  parameter int              LC_W    = 6,
  parameter logic [LC_W-1:0] LC_INIT = 6'h05,
  parameter logic [LC_W:0]   LC_POLY = 7'h61,
  parameter int              UNROLL  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [B-1:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [B-1:0] out_state,
  output logic         busy
);

  localparam int RCW = $clog2(R + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((R % UNROLL) != 0 || (B % 4) != 0) begin : g_bad_cfg
    $error("spongent_perm_iter: UNROLL must divide R and B must be a multiple of 4");
  end

  logic [1:0]      fsm;
  logic [B-1:0]    st;
  logic [LC_W-1:0] lc;
  logic [RCW-1:0]  rcnt;

  logic [B-1:0]    st_chain [UNROLL+1];
  logic [LC_W-1:0] lc_chain [UNROLL+1];

  assign st_chain[0] = st;
  assign lc_chain[0] = lc;

  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    spongent_round #(.B(B), .LC_W(LC_W)) u_round (
      .state_i (st_chain[u]),
      .lc_i    (lc_chain[u]),
      .state_o (st_chain[u+1])
    );
    assign lc_chain[u+1] = LC_W'(lc_step(32'(lc_chain[u]), 33'(LC_POLY), LC_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm  <= IDLE;
      st   <= '0;
      lc   <= LC_INIT;
      rcnt <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          st   <= in_state;
          lc   <= LC_INIT;
          rcnt <= '0;
          fsm  <= RUN;
        end
        RUN: begin
          st   <= st_chain[UNROLL];
          lc   <= lc_chain[UNROLL];
          rcnt <= rcnt + RCW'(UNROLL);
          if (rcnt == RCW'(R - UNROLL)) fsm <= DONE;
        end
        DONE: if (out_ready) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm == RUN);
  assign out_state = st;

endmodule

// File: tb/tb_spongent_perm_iter.sv
// Directed + randomized bench for spongent_perm_iter against a bit-level permutation model.
module tb_spongent_perm_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance (B=88, UNROLL=1)
  logic        iv0 = 1'b0, ir0, ov0, or0 = 1'b0, busy0;
  logic [87:0] is0 = '0, os0;
  // B=88, UNROLL=5
  logic        iv5 = 1'b0, ir5, ov5, or5 = 1'b0, busy5;
  logic [87:0] is5 = '0, os5;
  // B=136 variant
  logic         iv1 = 1'b0, ir1, ov1, or1 = 1'b0, busy1;
  logic [135:0] is1 = '0, os1;

  spongent_perm_iter dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_state(is0),
    .out_valid(ov0), .out_ready(or0), .out_state(os0), .busy(busy0)
  );

  spongent_perm_iter #(.UNROLL(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_state(is5),
    .out_valid(ov5), .out_ready(or5), .out_state(os5), .busy(busy5)
  );

  spongent_perm_iter #(.B(136), .R(70), .LC_W(7), .LC_INIT(7'h7A), .LC_POLY(8'hC1)) dut136 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_state(is1),
    .out_valid(ov1), .out_ready(or1), .out_state(os1), .busy(busy1)
  );

  int tests = 0;
  int fails = 0;

  int sb [16] = '{14, 13, 11, 0, 2, 1, 4, 15, 7, 10, 8, 5, 9, 12, 3, 6};

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Whole permutation straight from the round definition, one bit at a time.
  function automatic logic [135:0] model(input logic [135:0] din, input int b, input int r,
                                         input int lcw, input logic [31:0] lcinit,
                                         input logic [31:0] poly);
    logic [135:0] s, t;
    logic [31:0]  lc;
    logic         fb;
    s  = din;
    lc = lcinit;
    for (int i = 0; i < r; i++) begin
      for (int k = 0; k < lcw; k++) begin
        s[k]       = s[k] ^ lc[k];
        s[b-1-k]   = s[b-1-k] ^ lc[k];
      end
      t = '0;
      for (int n = 0; n < b / 4; n++) t[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
      s = '0;
      for (int j = 0; j < b - 1; j++) s[(j * b / 4) % (b - 1)] = t[j];
      s[b-1] = t[b-1];
      fb = 1'b0;
      for (int k = 1; k <= lcw; k++) fb = fb ^ (lc[k-1] & poly[k]);
      lc = ((lc << 1) | {31'd0, fb}) & ((32'd1 << lcw) - 32'd1);
    end
    return s;
  endfunction

  function automatic logic [135:0] rand_vec(input int b);
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = b; k < 160; k++) r[k] = 1'b0;
    return r[135:0];
  endfunction

  function automatic logic outv(input int w);
    return (w == 0) ? ov0 : (w == 1) ? ov5 : ov1;
  endfunction

  function automatic logic [135:0] outs(input int w);
    return (w == 0) ? 136'(os0) : (w == 1) ? 136'(os5) : os1;
  endfunction

  // Accept one input on instance w, wait (bounded) for out_valid, then release the result.
  task automatic run(input int w, input logic [135:0] d, output logic [135:0] res,
                     output int cyc);
    case (w)
      0:       begin is0 = d[87:0]; iv0 = 1'b1; end
      1:       begin is5 = d[87:0]; iv5 = 1'b1; end
      default: begin is1 = d;       iv1 = 1'b1; end
    endcase
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0; iv5 = 1'b0; iv1 = 1'b0;
    cyc = 0;
    while (!outv(w) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    res = outs(w);
    or0 = 1'b1; or5 = 1'b1; or1 = 1'b1;
    @(negedge clk);
    or0 = 1'b0; or5 = 1'b0; or1 = 1'b0;
  endtask

  logic [135:0] d, res, held, exp0;
  int cyc, busy_cnt;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 136'(ir0), 136'(1));
    check("rst_out_valid", 136'(ov0), 136'(0));
    check("rst_busy", 136'(busy0), 136'(0));
    check("rst_out_state", 136'(os0), 136'(0));
    rst = 1'b0;
    @(negedge clk);

    // single permutation of zero, lCounter probe, latency, busy width
    exp0 = model(136'(0), 88, 45, 6, 32'h05, 32'h61);
    is0 = '0; iv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    if (busy0) busy_cnt++;
    check("lc_round0", 136'(dut.lc), 136'(6'h05));
    @(negedge clk); cyc++; if (busy0) busy_cnt++;
    check("lc_round1", 136'(dut.lc), 136'(6'h0A));
    @(negedge clk); cyc++; if (busy0) busy_cnt++;
    check("lc_round2", 136'(dut.lc), 136'(6'h14));
    @(negedge clk); cyc++; if (busy0) busy_cnt++;
    check("lc_round3", 136'(dut.lc), 136'(6'h29));
    while (!ov0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (busy0) busy_cnt++;
    end
    check("latency_88", 136'(cyc), 136'(45));
    check("busy_cycles_88", 136'(busy_cnt), 136'(45));
    check("perm_zero_88", 136'(os0), exp0);
    held = 136'(os0);

    // backpressure: result held, new inputs ignored
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1) begin
        is0 = rand_vec(88);
        iv0 = 1'b1;
      end else begin
        iv0 = 1'b0;
      end
      @(negedge clk);
      check("bp_out_valid", 136'(ov0), 136'(1));
      check("bp_out_state", 136'(os0), held);
      check("bp_in_ready", 136'(ir0), 136'(0));
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    check("release_out_valid", 136'(ov0), 136'(0));
    check("release_in_ready", 136'(ir0), 136'(1));

    // randomized permutations on the default instance
    for (int i = 0; i < 3; i++) begin
      d = rand_vec(88);
      run(0, d, res, cyc);
      check("rand_latency_88", 136'(cyc), 136'(45));
      check("rand_perm_88", res, model(d, 88, 45, 6, 32'h05, 32'h61));
    end

    // asynchronous reset in the middle of a run
    is0 = rand_vec(88); iv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0;
    repeat (20) @(negedge clk);
    check("midrun_busy_before", 136'(busy0), 136'(1));
    rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", 136'(ir0), 136'(1));
    check("midrun_rst_out_valid", 136'(ov0), 136'(0));
    check("midrun_rst_busy", 136'(busy0), 136'(0));
    check("midrun_rst_out_state", 136'(os0), 136'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    d = rand_vec(88) | 136'({88{1'b1}});
    run(0, d, res, cyc);
    check("ones_latency_88", 136'(cyc), 136'(45));
    check("ones_perm_88", res, model(d, 88, 45, 6, 32'h05, 32'h61));

    // UNROLL=5 instance
    run(1, 136'(0), res, cyc);
    check("unroll5_latency", 136'(cyc), 136'(9));
    check("unroll5_perm_zero", res, exp0);
    d = rand_vec(88);
    run(1, d, res, cyc);
    check("unroll5_perm_rand", res, model(d, 88, 45, 6, 32'h05, 32'h61));

    // B=136 variant
    for (int i = 0; i < 2; i++) begin
      d = rand_vec(136);
      run(2, d, res, cyc);
      check("latency_136", 136'(cyc), 136'(70));
      check("perm_136", res, model(d, 136, 70, 7, 32'h7A, 32'hC1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
